// File: rtl/uart_receiver.sv
// UART receive path: oversampled start/data/stop recovery with sticky rdy, frame and overrun flags.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a low sample on an armed line
// START  | counting to mid start bit to confirm it is not a glitch
// DATA   | sampling data bits at mid-bit, LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit, then publishing the byte or flagging the frame
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [1:0]    sync;
  logic          rxs;
  logic [2:0]    state;
  logic [SW-1:0] scnt;
  logic [2:0]    bit_idx;
  logic [7:0]    scratch;
  logic          armed;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  assign rxs = sync[1];

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      state     <= IDLE;
      scnt      <= '0;
      bit_idx   <= '0;
      scratch   <= '0;
      armed     <= 1'b0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], rx};

      // a clear is overridden by a byte completing on the same cycle
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end

      if (clken) begin
        case (state)
          IDLE: begin
            // armed only rises on a high sample, so a held-low break cannot restart a frame
            if (rxs) begin
              armed <= 1'b1;
            end else if (armed) begin
              armed <= 1'b0;
              scnt  <= '0;
              state <= START;
            end
          end
          START: begin
            scnt <= scnt + SW'(1);
            if (scnt == MID_START) begin
              if (!rxs) begin
                scnt    <= '0;
                bit_idx <= '0;
                scratch <= '0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end
          end
          DATA: begin
            scnt <= scnt + SW'(1);
            if (scnt == MID_BIT) begin
              scratch[bit_idx] <= rxs;
              if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            scnt <= scnt + SW'(1);
            if (scnt == MID_BIT) begin
              par_bit <= rxs;
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            scnt <= scnt + SW'(1);
            if (scnt == MID_BIT) begin
              if (rxs) begin
                data      <= scratch;
                rdy       <= 1'b1;
                frame_err <= 1'b0;
                if (rdy) overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= ^scratch ^ par_bit;
`endif
              end else begin
                frame_err <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
